// File: rtl/mem_loader_port_if.sv
`timescale 1ns/1ps
// Host-side strobe/acknowledge bus of the memory loader port.
interface mem_loader_port_if #(
  parameter int DATA_W = 16
) ();
  logic              ext_strobe;
  logic [2:0]        ext_cmd;
  logic [DATA_W-1:0] ext_data_in;
  logic [DATA_W-1:0] ext_data_out;
  logic              ext_ack;
  logic [DATA_W-1:0] chk_sum;

  modport master (
    output ext_strobe, ext_cmd, ext_data_in,
    input  ext_data_out, ext_ack, chk_sum
  );

  modport slave (
    input  ext_strobe, ext_cmd, ext_data_in,
    output ext_data_out, ext_ack, chk_sum
  );
endinterface

// File: rtl/mem_loader_port.sv
`timescale 1ns/1ps
// Pad-side loader/debug port: a synchronised strobe/ack handshake loads, reads back
// and checksums instruction/data memory while start=0; start=1 hands memories to the core.
module mem_loader_port #(
  parameter int          DATA_W      = 16,
  parameter int          IADDR_W     = 13,
  parameter int          DADDR_W     = 8,
  parameter logic [15:0] NOP_INSTR   = 16'h2004,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  mem_loader_port_if.slave   host,
  input  logic [IADDR_W-1:0] uP_instr_mem_addr,
  output logic [DATA_W-1:0]  uP_instr,
  input  logic [DADDR_W-1:0] uP_data_mem_addr,
  input  logic [DATA_W-1:0]  uP_write_data,
  input  logic               uP_dataw_en,
  output logic [IADDR_W-1:0] instr_mem_addr,
  output logic               instrw_en,
  output logic [DATA_W-1:0]  instr_write_data,
  input  logic [DATA_W-1:0]  instr,
  output logic [DADDR_W-1:0] data_mem_addr,
  output logic               dataw_en,
  output logic [DATA_W-1:0]  data_write_data,
  input  logic [DATA_W-1:0]  data_read_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_CAPT = 2'd2,
    S_ACK  = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     stb_prev_q;
  logic [2:0]               cmd_q, cmd_d;
  logic [IADDR_W-1:0]       iaddr_q, iaddr_d;
  logic [DADDR_W-1:0]       daddr_q, daddr_d;
  logic [DATA_W-1:0]        sum_q, sum_d;
  logic [DATA_W-1:0]        dout_q, dout_d;
  logic                     ack_q, ack_d;
  logic                     stb_s, rise_s, wr_s, addr_s, isel_s, exec_s, capt_s, mem_wr_s;

  // Edges arriving while the core owns the memories are swallowed because stb_prev_q keeps tracking.
  assign stb_s    = sync_q[SYNC_STAGES-1];
  assign rise_s   = stb_s & ~stb_prev_q & ~start;
  assign {wr_s, addr_s, isel_s} = cmd_q;
  assign exec_s   = (state_q == S_EXEC) & ~start;
  assign capt_s   = (state_q == S_CAPT) & ~start;
  assign mem_wr_s = exec_s & wr_s & ~addr_s;

  // State register, strobe synchroniser and loader datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sync_q     <= {SYNC_STAGES{1'b0}};
      stb_prev_q <= 1'b0;
      cmd_q      <= 3'b000;
      iaddr_q    <= {IADDR_W{1'b0}};
      daddr_q    <= {DADDR_W{1'b0}};
      sum_q      <= {DATA_W{1'b0}};
      dout_q     <= {DATA_W{1'b0}};
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], host.ext_strobe};
      stb_prev_q <= stb_s;
      cmd_q      <= cmd_d;
      iaddr_q    <= iaddr_d;
      daddr_q    <= daddr_d;
      sum_q      <= sum_d;
      dout_q     <= dout_d;
      ack_q      <= ack_d;
    end
  end

  // Next-state logic; start forces IDLE from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rise_s) state_d = S_EXEC;
        else        state_d = S_IDLE;
      end
      S_EXEC:  state_d = S_CAPT;
      S_CAPT:  state_d = S_ACK;
      S_ACK: begin
        if (!stb_s) state_d = S_IDLE;
        else        state_d = S_ACK;
      end
      default: state_d = S_IDLE;
    endcase
    if (start) state_d = S_IDLE;
    else       state_d = state_d;
  end

  // Datapath next values: address loads and checksum in EXEC, read-back and increment in CAPT.
  always_comb begin
    iaddr_d = iaddr_q;
    daddr_d = daddr_q;
    sum_d   = sum_q;
    dout_d  = dout_q;
    ack_d   = (state_d == S_ACK);
    if (state_q == S_IDLE) cmd_d = host.ext_cmd;
    else                   cmd_d = cmd_q;

    if (exec_s && wr_s && addr_s) begin
      if (isel_s) begin
        iaddr_d = host.ext_data_in[IADDR_W-1:0];
        sum_d   = {DATA_W{1'b0}};
      end else begin
        daddr_d = host.ext_data_in[DADDR_W-1:0];
      end
    end else if (mem_wr_s && isel_s) begin
      sum_d = sum_q + host.ext_data_in;
    end else begin
      sum_d = sum_q;
    end

    if (capt_s) begin
      case ({wr_s, addr_s})
        2'b01:   dout_d = isel_s ? DATA_W'(iaddr_q) : DATA_W'(daddr_q);
        2'b00:   dout_d = isel_s ? instr : data_read_data;
        default: dout_d = host.ext_data_in;
      endcase
      if (!addr_s) begin
        if (isel_s) iaddr_d = iaddr_q + IADDR_W'(1);
        else        daddr_d = daddr_q + DADDR_W'(1);
      end else begin
        iaddr_d = iaddr_d;
      end
    end else begin
      dout_d = dout_q;
    end
  end

  assign host.ext_data_out = dout_q;
  assign host.ext_ack      = ack_q;
  assign host.chk_sum      = sum_q;

  // Write enables are gated by start combinationally so a rising start masks an in-flight write.
  assign instr_mem_addr   = start ? uP_instr_mem_addr : iaddr_q;
  assign instrw_en        = mem_wr_s & isel_s;
  assign instr_write_data = host.ext_data_in;
  assign data_mem_addr    = start ? uP_data_mem_addr : daddr_q;
  assign dataw_en         = start ? uP_dataw_en : (mem_wr_s & ~isel_s);
  assign data_write_data  = start ? uP_write_data : host.ext_data_in;
  assign uP_instr         = start ? instr : DATA_W'(NOP_INSTR);

endmodule
